isqrt_share_arb: RTL and testbench

Round-robin arbiter that shares one pipelined `isqrt` instance between `N_REQ` independent requesters. Each accepted operand travels through the shared pipeline with a requester tag, and the result is returned on a common response bus with that tag. The block sits in front of the square-root datapath wherever several formula pipes or clients would otherwise each need their own `isqrt` instance. It adds a pause/drain control and a busy indication for the system sequencer.

---
 rtl/isqrt_share_arb.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_isqrt_share_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_share_arb.sv
// isqrt_share_arb: round-robin arbiter sharing one pipelined isqrt
// between N_REQ requesters, with tagged responses, pause/drain and busy.
//
// Ports (isqrt_share_arb):
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   req_vld      per-requester request valid        [N_REQ]
//   req_x        per-requester operands             [N_REQ*32]
//   req_rdy      one-hot grant                      [N_REQ]
//   pause        block new grants, let pipeline drain
//   rsp_vld      result valid
//   rsp_id       owning requester of the result     [ID_W]
//   rsp_y        floor(sqrt(x))                     [16]
//   perf_grants  per-requester saturating grant counters [N_REQ*16]
//                (only with ISQRT_SHARE_ARB_PERF_EN defined)
//   busy         any operation in flight
//
// Ports (isqrt): clk_i, rst_i (sync, active-high), x_vld_i, x_i[32],
//   y_vld_o, y_o[16]; latency n_pipe_stages cycles (1..16).

module isqrt #(
    parameter int n_pipe_stages = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_vld_i,
    input  logic [31:0] x_i,
    output logic        y_vld_o,
    output logic [15:0] y_o
);
    localparam int S  = n_pipe_stages;
    // Only stages that feed another stage keep remainder/operand state.
    localparam int SM = (S > 1) ? S - 1 : 1;

    logic [S-1:0]           vld_q;
    logic [S-1:0]           vin;
    logic [S-1:0][15:0]     root_q, root_d;
    logic [SM-1:0][19:0]    rem_q, rem_d;
    logic [SM-1:0][31:0]    xs_q, xs_d;
    logic [19:0]            r, t;
    logic [15:0]            q;
    logic [31:0]            xv;

    // Restoring square root, one result bit per iteration; the 16
    // iterations are spread evenly over the S stages.
    always_comb begin
        rem_d  = '0;
        root_d = '0;
        xs_d   = '0;
        vin    = '0;
        r      = '0;
        q      = '0;
        xv     = '0;
        t      = '0;
        for (int s = 0; s < S; s++) begin
            if (s == 0) begin
                vin[s] = x_vld_i;
                r      = '0;
                q      = '0;
                xv     = x_i;
            end else begin
                vin[s] = vld_q[(s > 0) ? s - 1 : 0];
                r      = rem_q[(s > 0) ? s - 1 : 0];
                q      = root_q[(s > 0) ? s - 1 : 0];
                xv     = xs_q[(s > 0) ? s - 1 : 0];
            end
            for (int j = 0; j < 16; j++) begin
                if (j >= (s * 16) / S && j < ((s + 1) * 16) / S) begin
                    r  = {r[17:0], xv[31:30]};
                    xv = {xv[29:0], 2'b00};
                    t  = {2'b00, q, 2'b01};
                    if (r >= t) begin
                        r = r - t;
                        q = {q[14:0], 1'b1};
                    end else begin
                        q = {q[14:0], 1'b0};
                    end
                end
            end
            root_d[s] = q;
            if (s < S - 1) begin
                rem_d[(s < S - 1) ? s : 0] = r;
                xs_d[(s < S - 1) ? s : 0]  = xv;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q <= vin;
        end
    end

    // Datapath registers hold when their stage is idle.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < S; s++) begin
            if (vin[s]) begin
                root_q[s] <= root_d[s];
                if (s < S - 1) begin
                    rem_q[(s < S - 1) ? s : 0] <= rem_d[(s < S - 1) ? s : 0];
                    xs_q[(s < S - 1) ? s : 0]  <= xs_d[(s < S - 1) ? s : 0];
                end
            end
        end
    end

    assign y_vld_o = vld_q[S-1];
    assign y_o     = root_q[S-1];
endmodule

module isqrt_share_arb #(
    parameter int N_REQ        = 4,
    parameter int ISQRT_STAGES = 16,
    parameter int ID_W         = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_vld,
    input  logic [N_REQ*32-1:0]   req_x,
    output logic [N_REQ-1:0]      req_rdy,
    input  logic                  pause,
    output logic                  rsp_vld,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           rsp_y,
`ifdef ISQRT_SHARE_ARB_PERF_EN
    output logic [N_REQ*16-1:0]   perf_grants,
`endif
    output logic                  busy
);
    localparam int S = ISQRT_STAGES;

    typedef enum logic {RUN, PAUSE} state_e;

    state_e                  state_q, state_d;
    logic                    grant_en;
    logic [N_REQ-1:0]        gnt;
    logic [ID_W-1:0]         gnt_id;
    logic [31:0]             sel_x;
    logic                    found;
    logic                    acc;
    logic [ID_W-1:0]         last_q;
    logic                    in_vld_q;
    logic [31:0]             in_x_q;
    logic [ID_W-1:0]         in_id_q;
    logic [S-1:0]            tv_q;
    logic [S-1:0]            tvin;
    logic [S-1:0][ID_W-1:0]  tid_q;
    logic [S-1:0][ID_W-1:0]  tidin;
    logic                    y_vld;
    logic [15:0]             y;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A pause blocks grants in the same cycle; after release the block
    // spends one cycle returning to RUN before granting again.
    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        unique case (state_q)
            RUN: begin
                grant_en = !pause;
                if (pause) state_d = PAUSE;
            end
            PAUSE: begin
                if (!pause) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Round robin: first search above last_q, then wrap from 0.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        sel_x  = '0;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_vld[i] && ID_W'(i) > last_q) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
                sel_x  = req_x[32*i +: 32];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_vld[i] && ID_W'(i) <= last_q) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                gnt_id = ID_W'(i);
                sel_x  = req_x[32*i +: 32];
            end
        end
    end

    assign req_rdy = (rst && grant_en) ? gnt : '0;
    assign acc     = |(req_rdy & req_vld);

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q   <= ID_W'(N_REQ - 1);
            in_vld_q <= 1'b0;
        end else begin
            in_vld_q <= acc;
            if (acc) last_q <= gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            in_x_q  <= sel_x;
            in_id_q <= gnt_id;
        end
    end

    always_comb begin
        tvin  = '0;
        tidin = '0;
        for (int i = 0; i < S; i++) begin
            if (i == 0) begin
                tvin[i]  = in_vld_q;
                tidin[i] = in_id_q;
            end else begin
                tvin[i]  = tv_q[(i > 0) ? i - 1 : 0];
                tidin[i] = tid_q[(i > 0) ? i - 1 : 0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tv_q <= '0;
        end else begin
            tv_q <= tvin;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < S; i++) begin
            if (tvin[i]) tid_q[i] <= tidin[i];
        end
    end

    isqrt #(
        .n_pipe_stages(S)
    ) u_isqrt (
        .clk_i   (clk),
        .rst_i   (!rst),
        .x_vld_i (in_vld_q),
        .x_i     (in_x_q),
        .y_vld_o (y_vld),
        .y_o     (y)
    );

    // Unreset tag/result data is masked so idle outputs read as zero.
    assign rsp_vld = y_vld;
    assign rsp_id  = y_vld ? tid_q[S-1] : '0;
    assign rsp_y   = y_vld ? y : '0;
    assign busy    = in_vld_q | (|tv_q);

    tag_sync_a: assert property (@(posedge clk) disable iff (!rst)
        tv_q[S-1] == y_vld);

`ifdef ISQRT_SHARE_ARB_PERF_EN
    logic [N_REQ-1:0][15:0] perf_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_rdy[i] && req_vld[i] && perf_q[i] != 16'hFFFF)
                    perf_q[i] <= perf_q[i] + 16'd1;
            end
        end
    end

    assign perf_grants = perf_q;
`endif
endmodule

// File: tb/tb_isqrt_share_arb.sv
// tb_isqrt_share_arb: directed, table-driven bench for isqrt_share_arb
// (N_REQ=4, ISQRT_STAGES=16).

module tb_isqrt_share_arb;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           pause = 1'b0;
    logic [N-1:0]   req_vld = '0;
    logic [N*32-1:0] req_x = '0;
    logic [N-1:0]   req_rdy;
    logic           rsp_vld;
    logic [1:0]     rsp_id;
    logic [15:0]    rsp_y;
    logic           busy;
`ifdef ISQRT_SHARE_ARB_PERF_EN
    logic [N*16-1:0] perf_grants;
`endif

    isqrt_share_arb #(
        .N_REQ(N),
        .ISQRT_STAGES(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_x   (req_x),
        .req_rdy (req_rdy),
        .pause   (pause),
        .rsp_vld (rsp_vld),
        .rsp_id  (rsp_id),
        .rsp_y   (rsp_y),
`ifdef ISQRT_SHARE_ARB_PERF_EN
        .perf_grants (perf_grants),
`endif
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] y;
        int          cyc;
    } rsp_t;
    rsp_t rq[$];

    always @(negedge clk) begin
        if (rsp_vld) rq.push_back('{rsp_id, rsp_y, cnt});
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_vld = '0;
        pause = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    typedef struct {
        int          rq;
        logic [31:0] x;
        logic [15:0] y;
    } vec_t;
    vec_t vecs[12];

    int g0, last, bfall, hit;

    initial begin
        vecs[0]  = '{1, 32'd144,        16'd12};
        vecs[1]  = '{2, 32'd0,          16'd0};
        vecs[2]  = '{2, 32'd1,          16'd1};
        vecs[3]  = '{2, 32'hFFFE_0000,  16'hFFFE};
        vecs[4]  = '{2, 32'hFFFF_FFFF,  16'hFFFF};
        vecs[5]  = '{0, 32'hFFFE_0001,  16'hFFFF};
        vecs[6]  = '{3, 32'd15,         16'd3};
        vecs[7]  = '{3, 32'd16,         16'd4};
        vecs[8]  = '{0, 32'd1000000,    16'd1000};
        vecs[9]  = '{1, 32'd99,         16'd9};
        vecs[10] = '{0, 32'd2,          16'd1};
        vecs[11] = '{3, 32'h4000_0000,  16'h8000};

        // Reset state, with requests pending
        req_vld = 4'hF;
        step();
        step();
        chk("rst_rdy", 64'(req_rdy), 64'h0);
        chk("rst_rsp_vld", 64'(rsp_vld), 64'h0);
        chk("rst_rsp_id", 64'(rsp_id), 64'h0);
        chk("rst_rsp_y", 64'(rsp_y), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        req_vld = '0;
        rst = 1'b1;
        step();

        // Single-shot vectors
        for (int i = 0; i < 12; i++) begin
            rq.delete();
            req_x = '0;
            req_x[32*vecs[i].rq +: 32] = vecs[i].x;
            req_vld = '0;
            req_vld[vecs[i].rq] = 1'b1;
            #1;
            chk($sformatf("vec%0d_rdy", i), 64'(req_rdy),
                64'(1) << vecs[i].rq);
            g0 = cnt;
            step();
            req_vld = '0;
            repeat (20) step();
            chk($sformatf("vec%0d_nrsp", i), 64'(rq.size()), 64'd1);
            if (rq.size() >= 1) begin
                chk($sformatf("vec%0d_id", i), 64'(rq[0].id),
                    64'(vecs[i].rq));
                chk($sformatf("vec%0d_y", i), 64'(rq[0].y), 64'(vecs[i].y));
                chk($sformatf("vec%0d_lat", i), 64'(rq[0].cyc - g0),
                    64'd17);
            end
        end

        // Round robin over all four requesters
        do_reset();
        rq.delete();
        for (int i = 0; i < N; i++) req_x[32*i +: 32] = 4 * (i + 1) * (i + 1);
        req_vld = 4'hF;
        g0 = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k == 0) g0 = cnt;
            chk($sformatf("rr_gnt%0d", k), 64'(req_rdy),
                64'(1) << (k % 4));
            step();
        end
        req_vld = '0;
        repeat (30) step();
        chk("rr_nrsp", 64'(rq.size()), 64'd8);
        for (int k = 0; k < rq.size(); k++) begin
            chk($sformatf("rr_id%0d", k), 64'(rq[k].id), 64'(k % 4));
            chk($sformatf("rr_y%0d", k), 64'(rq[k].y), 64'(2 * (k % 4 + 1)));
            chk($sformatf("rr_cyc%0d", k), 64'(rq[k].cyc - g0),
                64'(17 + k));
        end

        // Single requester: granted every cycle
        do_reset();
        rq.delete();
        req_x[64 +: 32] = 32'd49;
        req_vld = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("solo_gnt%0d", k), 64'(req_rdy), 64'h4);
            step();
        end
        req_vld = '0;
        repeat (25) step();
        chk("solo_nrsp", 64'(rq.size()), 64'd6);
        for (int k = 1; k < rq.size(); k++) begin
            chk($sformatf("solo_cyc%0d", k), 64'(rq[k].cyc - rq[k-1].cyc),
                64'd1);
            chk($sformatf("solo_y%0d", k), 64'({rq[k].id, rq[k].y}),
                64'({2'd2, 16'd7}));
        end

        // Pause and drain
        do_reset();
        rq.delete();
        req_vld = 4'hF;
        last = -1;
        bfall = -1;
        hit = 0;
        g0 = 0;
        for (int c = 0; c < 25; c++) begin
            if (c == 3) pause = 1'b1;
            #1;
            if (c == 0) g0 = cnt;
            if (c < 3) begin
                chk($sformatf("pz_gnt%0d", c), 64'(req_rdy), 64'(1) << c);
            end else if (req_rdy != '0) begin
                hit++;
            end
            if (rsp_vld) last = cnt;
            if (!busy && bfall < 0 && last >= 0) bfall = cnt;
            step();
        end
        chk("pz_no_gnt", 64'(hit), 64'd0);
        chk("pz_nrsp", 64'(rq.size()), 64'd3);
        chk("pz_last", 64'(last - g0), 64'd19);
        chk("pz_busy_fall", 64'(bfall - last), 64'd1);
        pause = 1'b0;
        hit = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (hit == 0 && req_rdy != '0) begin
                hit = 1;
                chk("pz_resume", 64'(req_rdy), 64'h8);
            end
            step();
        end
        chk("pz_resumed", 64'(hit), 64'd1);
        req_vld = '0;
        repeat (25) step();

        // Reset with operations in flight
        do_reset();
        req_x[32 +: 32] = 32'd16;
        req_vld = 4'hF;
        repeat (5) step();
        req_vld = '0;
        repeat (5) step();
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        req_vld = 4'b1110;
        #1;
        chk("mid_rst_rdy", 64'(req_rdy), 64'h0);
        step();
        step();
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        rq.delete();
        rst = 1'b1;
        #1;
        chk("mid_first_gnt", 64'(req_rdy), 64'h2);
        step();
        req_vld = '0;
        repeat (25) step();
        chk("mid_nrsp", 64'(rq.size()), 64'd1);
        if (rq.size() >= 1) begin
            chk("mid_rsp", 64'({rq[0].id, rq[0].y}), 64'({2'd1, 16'd4}));
        end

`ifdef ISQRT_SHARE_ARB_PERF_EN
        do_reset();
        req_vld = 4'b0001;
        repeat (10) step();
        chk("perf_10", 64'(perf_grants[15:0]), 64'd10);
        repeat (70000) step();
        chk("perf_sat", 64'(perf_grants[15:0]), 64'hFFFF);
        chk("perf_others", 64'(perf_grants[63:16]), 64'h0);
        req_vld = '0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
